kbd_fifo: RTL and testbench

Scancode buffer between the PS/2 receiver and the port controller. It captures each byte strobed by the receiver into a 16-entry FIFO and raises a keyboard interrupt request through a request/acknowledge handshake. It presents the head byte for the CPU's port read of 60h and pops that byte on the read strobe. Bytes that arrive while the CPU is servicing an earlier interrupt are held, not lost.

---
 rtl/kbd_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/kbd_fifo.sv | 106 ++++++++++
 tb/tb_kbd_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard scancode path: FSM states, default sizing
// and the port-controller addresses that reach the scancode buffer.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2,
    ST_HOLD = 2'd3
  } kbd_state_e;

  localparam int KBD_DEPTH = 16;
  localparam int KBD_HOLD  = 16;

  localparam logic [7:0] KBD_PORT_DATA   = 8'h60;
  localparam logic [7:0] KBD_PORT_STATUS = 8'h64;

  // True for either keyboard-controller port address.
  function automatic logic kbd_port_hit(input logic [7:0] addr);
    return (addr == KBD_PORT_DATA) || (addr == KBD_PORT_STATUS);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with an explicit occupancy counter; a same-cycle push is
// accepted when full as long as a pop frees the slot in that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    empty   = (count_r == '0);
    full    = (count_r == CNT_FULL);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    if (empty) begin
      rdata = '0;
    end else begin
      rdata = mem[head_r];
    end
  end

  assign count = count_r;

  // Storage needs no reset: nothing reads a slot before it has been written.
  always_ff @(posedge clock) begin
    if (push_ok && !reset && !clr) begin
      mem[tail_r] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (pop_ok) begin
        head_r <= head_r + PTR_ONE;
      end
      if (push_ok) begin
        tail_r <= tail_r + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/kbd_fifo.sv
// Keyboard scancode buffer: queues bytes from the PS/2 receiver, raises an
// interrupt request with ack/read handshake and a quiet period after each pop.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = KBD_DEPTH,
  parameter int HOLD  = KBD_HOLD
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ps2_hit,
  input  logic [7:0]              ps2_data,
  input  logic                    rd,
  input  logic                    clr,
  input  logic                    irq_ack,
  output logic [7:0]              data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    ready,
  output logic                    overflow,
  output logic                    irq
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

  logic       fifo_empty;
  logic       fifo_full;
  kbd_state_e state_r;
  logic [7:0] hold_cnt_r;
  logic       irq_r;
  logic       overflow_r;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .push  (ps2_hit),
    .pop   (rd),
    .wdata (ps2_data),
    .rdata (data),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ready    = !fifo_empty;
  assign overflow = overflow_r;
  assign irq      = irq_r;

  // A full FIFO only drops the byte when no pop frees a slot in that cycle.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      overflow_r <= 1'b0;
    end else if (ps2_hit && fifo_full && !rd) begin
      overflow_r <= 1'b1;
    end
  end

  // Interrupt handshake; irq is high exactly while the request is pending.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      state_r    <= ST_IDLE;
      irq_r      <= 1'b0;
      hold_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_r <= ST_PEND;
            irq_r   <= 1'b1;
          end
        end
        ST_PEND: begin
          if (irq_ack) begin
            state_r <= ST_SERV;
            irq_r   <= 1'b0;
          end else if (rd) begin
            state_r    <= ST_HOLD;
            irq_r      <= 1'b0;
            hold_cnt_r <= HOLD_LOAD;
          end
        end
        ST_SERV: begin
          if (rd) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_r == 8'd0) begin
            state_r <= ST_IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          irq_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_fifo.sv
// Self-checking bench for kbd_fifo: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_kbd_fifo;

  localparam int DEPTH = 16;
  localparam int HOLD  = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_hit = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic       irq_ack = 1'b0;
  logic [7:0] data;
  logic [4:0] count;
  logic       ready;
  logic       overflow;
  logic       irq;

  int tests = 0;
  int fails = 0;

  kbd_fifo #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_hit  (ps2_hit),
    .ps2_data (ps2_data),
    .rd       (rd),
    .clr      (clr),
    .irq_ack  (irq_ack),
    .data     (data),
    .count    (count),
    .ready    (ready),
    .overflow (overflow),
    .irq      (irq)
  );

  always #20 clock = ~clock;

  // Behavioural model: a byte queue plus the interrupt expressed as
  // "waiting for ack", "in service" and "quiet until edge N".
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_serv = 1'b0;
  int         quiet_until = -1;
  int         edge_no = 0;
  bit         check_en = 1'b0;

  task automatic model_edge(input bit h, input logic [7:0] d, input bit r,
                            input bit a, input bit c, input bit rs);
    int  sz;
    bit  idle_before;
    sz = mq.size();
    if (rs || c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_pend = 1'b0;
      m_serv = 1'b0;
      quiet_until = -1;
    end else begin
      idle_before = !m_pend && !m_serv && (edge_no > quiet_until);
      if (m_pend) begin
        if (a) begin
          m_pend = 1'b0;
          m_serv = 1'b1;
        end else if (r) begin
          m_pend = 1'b0;
          quiet_until = edge_no + HOLD;
        end
      end else if (m_serv) begin
        if (r) begin
          m_serv = 1'b0;
          quiet_until = edge_no + HOLD;
        end
      end else if (idle_before && sz != 0) begin
        m_pend = 1'b1;
      end
      if (r && sz > 0) void'(mq.pop_front());
      if (h) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    edge_no++;
  endtask

  task automatic step(input bit h, input logic [7:0] d, input bit r,
                      input bit a, input bit c, input bit rs);
    ps2_hit = h; ps2_data = d; rd = r; irq_ack = a; clr = c; reset = rs;
    @(posedge clock);
    model_edge(h, d, r, a, c, rs);
    #1;
    ps2_hit = 1'b0; ps2_data = 8'h00; rd = 1'b0; irq_ack = 1'b0; clr = 1'b0; reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    logic [7:0] exp_data;
    if (check_en) begin
      exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
      tests++;
      if (data !== exp_data || count !== 5'(mq.size()) || ready !== (mq.size() != 0)
          || overflow !== m_ovf || irq !== m_pend) begin
        fails++;
        $display("FAIL cycle %0d: data=%0h/%0h count=%0d/%0d ready=%0b/%0b ovf=%0b/%0b irq=%0b/%0b",
                 edge_no, data, exp_data, count, mq.size(), ready, (mq.size() != 0),
                 overflow, m_ovf, irq, m_pend);
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] exp_b;
    int r;

    // Reset values
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_en = 1'b1;
    chk("rst_data", data, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_irq", irq, 0);

    // Single byte with ack then read
    step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_count", count, 1);
    chk("single_data", data, 8'h1C);
    chk("single_irq_early", irq, 0);
    idle(1);
    chk("single_irq", irq, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("single_ack", irq, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_rd_count", count, 0);
    chk("single_rd_data", data, 8'h00);
    idle(HOLD + 4);
    chk("single_stays_idle", irq, 0);

    // Back-to-back: three bytes serviced one interrupt at a time
    step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_irq", irq, 1);
    for (int i = 0; i < 3; i++) begin
      exp_b = (i == 0) ? 8'h1C : ((i == 1) ? 8'h32 : 8'h21);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("b2b_data", data, exp_b);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("b2b_irq_after_pop", irq, 0);
      idle(HOLD);
      chk("b2b_hold_quiet", irq, 0);
      idle(1);
      chk("b2b_reassert", irq, (i < 2) ? 1 : 0);
    end

    // Overflow: 17 pushes, 16 kept
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", data, 8'h01);
    for (int i = 1; i <= 16; i++) begin
      chk("ovf_drain", data, i);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("ovf_drained", count, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", overflow, 0);

    // Simultaneous push/pop while full
    for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_pp_count", count, 16);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_head", data, 8'h21);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'h21 + 8'(i) : 8'hAA;
      chk("full_pp_drain", data, exp_b);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Empty corner cases
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_rd_count", count, 0);
    chk("empty_rd_data", data, 8'h00);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_pp_count", count, 1);
    chk("empty_pp_data", data, 8'h5A);

    // Flush with pending irq and a same-cycle hit
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_irq_before", irq, 1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_irq", irq, 0);
    chk("flush_data", data, 8'h00);

    // Reset during HOLD
    step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_irq", irq, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("hrst_data", data, 8'h00);
    chk("hrst_count", count, 0);
    chk("hrst_ready", ready, 0);
    chk("hrst_ovf", overflow, 0);
    chk("hrst_irq", irq, 0);
    idle(HOLD + 4);
    chk("hrst_irq_idle", irq, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      b = 8'($urandom);
      step(($urandom_range(0, 99) < 45), b, ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 20), (r < 10), (r >= 995));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
